// File: rtl/mips_trace_buffer_if.sv
// rtl/mips_trace_buffer_if.sv - data-bus sample, trigger setup and readout signals of the trace buffer
// master drives the core bus, trigger and control inputs; slave is the trace buffer itself.
interface mips_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] direccion;
  logic [DATA_W-1:0] palabra;
  logic [DATA_W-1:0] leer_dato;
  logic              sample_en;
  logic              arm;
  logic [DATA_W-1:0] trig_addr;
  logic [DATA_W-1:0] trig_mask;
  logic              rd_en;
  logic [1:0]        state;
  logic              done;
  logic [CW-1:0]     count;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_palabra;
  logic [DATA_W-1:0] rd_leer_dato;
  logic [31:0]       rd_stamp;

  modport master (
    output direccion, palabra, leer_dato, sample_en, arm, trig_addr, trig_mask, rd_en,
    input  state, done, count, rd_valid, rd_addr, rd_palabra, rd_leer_dato, rd_stamp
  );

  modport slave (
    input  direccion, palabra, leer_dato, sample_en, arm, trig_addr, trig_mask, rd_en,
    output state, done, count, rd_valid, rd_addr, rd_palabra, rd_leer_dato, rd_stamp
  );
endinterface

// File: rtl/mips_trace_buffer.sv
// rtl/mips_trace_buffer.sv - circular trace capture of the MIPS data bus with address trigger and oldest-first readout
// Optional feature: define TRACE_TIMESTAMP_EN to store a free-running cycle stamp with each sample.
module mips_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 16
) (
  input logic                 clk,
  input logic                 rst,
  mips_trace_buffer_if.slave  bus
);
  localparam int AW        = $clog2(DEPTH);
  localparam int POST_LAST = (POST_TRIG == 0) ? 0 : POST_TRIG - 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_store;
  logic              w_clear;
  logic              w_read;
  logic              w_match;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_post_cnt;
  logic [AW:0]       r_count;
  logic [AW-1:0]     w_wr_inc;
  logic [AW:0]       w_count_inc;
  logic              r_done;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_palabra;
  logic [DATA_W-1:0] r_rd_leer;

  logic [DATA_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_pal  [DEPTH];
  logic [DATA_W-1:0] r_mem_leer [DEPTH];

  assign w_match     = bus.sample_en && (((bus.direccion ^ bus.trig_addr) & bus.trig_mask) == '0);
  assign w_wr_inc    = r_wr_ptr + 1'b1;
  assign w_count_inc = (r_count == FULL) ? FULL : r_count + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_clear     = 1'b0;
    w_read      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.arm) begin
          w_state_nxt = S_ARMED;
          w_clear     = 1'b1;
        end
      end
      S_ARMED: begin
        w_store = bus.sample_en;
        if (w_match) w_state_nxt = (POST_TRIG == 0) ? S_DONE : S_POST;
      end
      S_POST: begin
        w_store = bus.sample_en;
        if (bus.sample_en && r_post_cnt == POST_LAST[AW-1:0]) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.arm) begin
          w_state_nxt = S_ARMED;
          w_clear     = 1'b1;
        end else if (bus.rd_en && r_count != '0) begin
          w_read = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Entry into DONE always coincides with a store, so the oldest entry is computed from the post-store values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_post_cnt   <= '0;
      r_count      <= '0;
      r_done       <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_palabra <= '0;
      r_rd_leer    <= '0;
    end else begin
      if (w_clear) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_post_cnt <= '0;
        r_count    <= '0;
      end
      if (w_store) begin
        r_wr_ptr <= w_wr_inc;
        r_count  <= w_count_inc;
        if (r_state == S_POST) r_post_cnt <= r_post_cnt + 1'b1;
      end
      if (w_state_nxt == S_DONE && r_state != S_DONE) r_rd_ptr <= w_wr_inc - w_count_inc[AW-1:0];
      if (w_read) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_count      <= r_count - 1'b1;
        r_rd_addr    <= r_mem_addr[r_rd_ptr];
        r_rd_palabra <= r_mem_pal[r_rd_ptr];
        r_rd_leer    <= r_mem_leer[r_rd_ptr];
      end
      r_rd_valid <= w_read;
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem_addr[r_wr_ptr] <= bus.direccion;
      r_mem_pal[r_wr_ptr]  <= bus.palabra;
      r_mem_leer[r_wr_ptr] <= bus.leer_dato;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] r_stamp;
  logic [31:0] r_rd_stamp;
  logic [31:0] r_mem_stamp [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stamp    <= '0;
      r_rd_stamp <= '0;
    end else begin
      r_stamp <= r_stamp + 1'b1;
      if (w_read) r_rd_stamp <= r_mem_stamp[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem_stamp[r_wr_ptr] <= r_stamp;
  end

  assign bus.rd_stamp = r_rd_stamp;
`else
  assign bus.rd_stamp = '0;
`endif

  assign bus.state        = r_state;
  assign bus.done         = r_done;
  assign bus.count        = r_count;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_addr      = r_rd_addr;
  assign bus.rd_palabra   = r_rd_palabra;
  assign bus.rd_leer_dato = r_rd_leer;
endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Synthesizable, parametrised on-chip trace capture for the MIPS core's data-memory bus (`direccion`, `palabra`, `leer_dato`). It sits beside the `MIPS` top level, samples bus cycles into a circular buffer while armed, stops a programmable number of samples after an address-match trigger, and then allows the frozen window to be read out oldest-first. It replaces waveform-only inspection with a self-contained capture that both simulation benches and hardware bring-up can read.

## Interface

**Parameters**

- `DATA_W`, 32: width of the address and data buses.
- `DEPTH`, 64: buffer entries. Must be a power of two and at least 4.
- `POST_TRIG`, 16: samples stored after the trigger sample. Legal range is 0 to `DEPTH`-1.

**Ports**

- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous and active-low.
- `direccion` in `DATA_W`: bus address from the core.
- `palabra` in `DATA_W`: bus write data.
- `leer_dato` in `DATA_W`: bus read data.
- `sample_en` in 1: the bus values are a valid sample this cycle.
- `arm` in 1: one-cycle pulse that starts a capture.
- `trig_addr` in `DATA_W`: trigger address.
- `trig_mask` in `DATA_W`: bit set means that address bit is compared.
- `rd_en` in 1: pop one entry during readout.
- `state` out 2: 00 IDLE, 01 ARMED, 10 POST, 11 DONE.
- `done` out 1: high while `state` is DONE.
- `count` out log2(`DEPTH`)+1: number of valid entries captured.
- `rd_valid` out 1: the `rd_*` data outputs are valid this cycle.
- `rd_addr`, `rd_palabra`, `rd_leer_dato` out `DATA_W` each: the popped entry.
- `rd_stamp` out 32: timestamp of the popped entry.

## Operation

- **Reset (`rst`=0):** `state` goes to IDLE. `count`, the write pointer, the read pointer, the post-trigger counter, `rd_valid`, `done` and all `rd_*` outputs go to 0. Buffer memory is not cleared. Reset mid-capture or mid-readout discards the capture.
- **IDLE:**
  - `arm` moves the block to ARMED and clears `count` and the pointers.
  - A sample on the same cycle as `arm` is not stored.
- **ARMED:**
  - Each `sample_en` writes {`direccion`, `palabra`, `leer_dato`[, stamp]} at the write pointer.
  - The write pointer increments and wraps modulo `DEPTH`.
  - `count` saturates at `DEPTH`.
- **Trigger condition:** `sample_en` is high and ((`direccion` XOR `trig_addr`) AND `trig_mask`) equals 0.
  - The triggering sample is stored.
  - If `POST_TRIG` is 0, go straight to DONE; otherwise go to POST.
- **POST:**
  - Stores samples exactly as in ARMED.
  - After `POST_TRIG` further stored samples, go to DONE.
  - Further trigger matches are ignored.
- **DONE:**
  - The buffer is frozen; `sample_en` is ignored.
  - The read pointer starts at the oldest entry: (write pointer − `count`) mod `DEPTH`.
  - Each `rd_en` while `count` > 0 outputs the entry, advances the read pointer and decrements `count`.
  - `rd_en` while `count` is 0 leaves `rd_valid` low and changes nothing.
  - `rd_en` in any state other than DONE is ignored.
- **`arm` outside IDLE:**
  - In DONE it restarts the capture: ARMED, `count` cleared.
  - In ARMED or POST it is ignored.

## Timing

- Sample write, trigger detection, state change and `count` update all take effect on the same edge as the sampled cycle.
- `done` is registered. It is high in the cycle after the edge that stores the last post-trigger sample.
- Read latency is 1:
  - `rd_en` sampled at edge k puts the entry on `rd_*` with `rd_valid`=1 during cycle k+1.
  - `rd_valid` drops after one cycle unless `rd_en` is held.
  - Back-to-back `rd_en` gives one entry per cycle.
- `rd_*` data holds its last value when `rd_valid` is low.

## Configuration

- **`TRACE_TIMESTAMP_EN` defined:**
  - A free-running 32-bit cycle counter resets to 0, increments every `clk` edge and wraps.
  - Its value is stored with each sample and returned on `rd_stamp`.
- **`TRACE_TIMESTAMP_EN` undefined:**
  - No counter and no stamp storage.
  - `rd_stamp` is tied to 0.

## Test plan

All scenarios use `DEPTH`=8 and `POST_TRIG`=2.

1. **Reset:** hold `rst`=0 for 2 cycles, then release → `state`=00, `count`=0, `done`=0, `rd_valid`=0.
2. **Basic capture:**
   - Stimulus: `trig_addr`=0x14, `trig_mask`=0xFFFFFFFF, arm, then samples with `direccion` 0x00, 0x04, … 0x1C.
   - Required response: `done`=1, `count`=8; 8 reads return 0x00 through 0x1C in order, with `rd_palabra` and `rd_leer_dato` matching the stimulus.
3. **Wrap-around:**
   - Stimulus: same trigger settings except `trig_addr`=0x34; samples 0x00 through 0x3C.
   - Required response: DONE after 0x3C, `count`=8; reads return 0x20 through 0x3C.
4. **Early trigger and underflow:**
   - Stimulus: `trig_addr`=0x04; samples 0x00, 0x04, 0x08, 0x0C.
   - Required response: `count`=4; reads return 0x00, 0x04, 0x08, 0x0C; a fifth `rd_en` leaves `rd_valid`=0.
5. **Masked trigger:**
   - Stimulus: `trig_mask`=0xFFFFFF00, `trig_addr`=0x100; samples 0x0F0, 0x1A4, 0x1A8, 0x1AC.
   - Required response: trigger on 0x1A4 and DONE after 0x1AC. With `TRACE_TIMESTAMP_EN` defined, `rd_stamp` values strictly increase.
6. **Reset mid-operation:** drive `rst`=0 while in POST → immediately `state`=00, `count`=0, `done`=0; a later `arm` captures normally.
